// File: rtl/board_state_ctl.sv
// -----------------------------------------------------------------------------
// board_state_ctl
// Tic-tac-toe board controller. Turns mouse clicks on a 1024x768 screen into
// moves on a 3x3 board, alternates players, and detects win / draw.
//
// Ports
//   pclk          pixel clock, all state updates on its rising edge
//   rst           synchronous active-high reset
//   xpos, ypos    mouse pixel position (x 0..1023, y 0..767 valid)
//   mouse_left    left button level, synchronous to pclk
//   start_en      game screen enabled
//   choice_en     colour-choice screen active (game runs only when low)
//   first_player  colour of the first mover: 0 blue, 1 yellow
//   square_taken  bit i set: square i+1 occupied
//   square_color  bit i: owner of square i+1 (0 blue, 1 yellow)
//   turn          colour of the player to move
//   winner        00 none, 01 blue, 10 yellow, 11 draw
//   game_over     game finished, clicks ignored
// -----------------------------------------------------------------------------
module board_state_ctl (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    input  logic        choice_en,
    input  logic        first_player,
    output logic [8:0]  square_taken,
    output logic [8:0]  square_color,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over
);

    localparam int unsigned COORD_W = 12;
    localparam int unsigned NUM_SQ  = 9;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] NO_SQ = IDX_W'(15);

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_BLUE   = 2'b01;
    localparam logic [1:0] WIN_YELLOW = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_CLICK = 3'd1,
        S_DECODE     = 3'd2,
        S_UPDATE     = 3'd3,
        S_CHECK      = 3'd4,
        S_OVER       = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic                 mouse_prev_q, mouse_prev_d;   // registered mouse_left
    logic [COORD_W-1:0]   x_cap_q, x_cap_d;
    logic [COORD_W-1:0]   y_cap_q, y_cap_d;
    logic [IDX_W-1:0]     sq_idx_q, sq_idx_d;
    logic [NUM_SQ-1:0]    taken_q, taken_d;
    logic [NUM_SQ-1:0]    color_q, color_d;
    logic                 turn_q, turn_d;
    logic [1:0]           winner_q, winner_d;
    logic                 over_q, over_d;

    logic                 click_c;
    logic                 active_c;
    logic [1:0]           col_c, row_c;
    logic [IDX_W-1:0]     sq_c;
    logic [NUM_SQ-1:0]    sq_mask_c;
    logic                 blue_line_c, yellow_line_c;

    // Column of a pixel x; 3 means grid gap or off-screen.
    function automatic logic [1:0] col_of(input logic [COORD_W-1:0] x);
        if (x <= COORD_W'(339))                               return 2'd0;
        else if (x >= COORD_W'(342) && x <= COORD_W'(682))    return 2'd1;
        else if (x >= COORD_W'(685) && x <= COORD_W'(1023))   return 2'd2;
        else                                                  return 2'd3;
    endfunction

    // Row of a pixel y; 3 means grid gap or off-screen.
    function automatic logic [1:0] row_of(input logic [COORD_W-1:0] y);
        if (y <= COORD_W'(256))                               return 2'd0;
        else if (y >= COORD_W'(259) && y <= COORD_W'(507))    return 2'd1;
        else if (y >= COORD_W'(510) && y <= COORD_W'(767))    return 2'd2;
        else                                                  return 2'd3;
    endfunction

    // True when the ownership mask covers any row, column or diagonal.
    function automatic logic has_line(input logic [NUM_SQ-1:0] m);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    // Square decode from the captured coordinates.
    always_comb begin
        col_c = col_of(x_cap_q);
        row_c = row_of(y_cap_q);
        sq_c  = NO_SQ;
        if (col_c != 2'd3 && row_c != 2'd3) begin
            sq_c = IDX_W'({2'b00, row_c} * 4'd3 + {2'b00, col_c});
        end
    end

    assign click_c       = mouse_left & ~mouse_prev_q;
    assign active_c      = start_en & ~choice_en;
    assign sq_mask_c     = NUM_SQ'(1) << sq_idx_q;
    assign blue_line_c   = has_line(taken_q & ~color_q);
    assign yellow_line_c = has_line(taken_q & color_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        mouse_prev_d = mouse_left;
        x_cap_d      = x_cap_q;
        y_cap_d      = y_cap_q;
        sq_idx_d     = sq_idx_q;
        taken_d      = taken_q;
        color_d      = color_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        over_d       = over_q;

        case (state_q)
            S_IDLE: begin
                if (active_c) begin
                    state_d  = S_WAIT_CLICK;
                    taken_d  = '0;
                    color_d  = '0;
                    winner_d = WIN_NONE;
                    over_d   = 1'b0;
                    turn_d   = first_player;
                end
            end
            S_WAIT_CLICK: begin
                if (!active_c) begin
                    state_d = S_IDLE;
                end else if (click_c) begin
                    x_cap_d = xpos;
                    y_cap_d = ypos;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!active_c) begin
                    state_d = S_IDLE;
                end else begin
                    sq_idx_d = sq_c;
                    state_d  = (sq_c == NO_SQ) ? S_WAIT_CLICK : S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (!active_c) begin
                    state_d = S_IDLE;
                end else if ((taken_q & sq_mask_c) == '0) begin
                    taken_d = taken_q | sq_mask_c;
                    color_d = turn_q ? (color_q | sq_mask_c) : (color_q & ~sq_mask_c);
                    turn_d  = ~turn_q;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT_CLICK;
                end
            end
            S_CHECK: begin
                // A completed line wins even when it fills the board.
                if (!active_c) begin
                    state_d = S_IDLE;
                end else if (blue_line_c) begin
                    winner_d = WIN_BLUE;
                    over_d   = 1'b1;
                    state_d  = S_OVER;
                end else if (yellow_line_c) begin
                    winner_d = WIN_YELLOW;
                    over_d   = 1'b1;
                    state_d  = S_OVER;
                end else if (&taken_q) begin
                    winner_d = WIN_DRAW;
                    over_d   = 1'b1;
                    state_d  = S_OVER;
                end else begin
                    state_d = S_WAIT_CLICK;
                end
            end
            S_OVER: begin
                if (!active_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mouse_prev_q <= 1'b0;
            x_cap_q      <= '0;
            y_cap_q      <= '0;
            sq_idx_q     <= '0;
            taken_q      <= '0;
            color_q      <= '0;
            turn_q       <= 1'b0;
            winner_q     <= WIN_NONE;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mouse_prev_q <= mouse_prev_d;
            x_cap_q      <= x_cap_d;
            y_cap_q      <= y_cap_d;
            sq_idx_q     <= sq_idx_d;
            taken_q      <= taken_d;
            color_q      <= color_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            over_q       <= over_d;
        end
    end

    assign square_taken = taken_q;
    assign square_color = color_q;
    assign turn         = turn_q;
    assign winner       = winner_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_board_state_ctl.sv
// -----------------------------------------------------------------------------
// tb_board_state_ctl
// Drives clicks into board_state_ctl and compares the board, turn, winner and
// game_over against a move-level tic-tac-toe model kept in the bench.
// -----------------------------------------------------------------------------
module tb_board_state_ctl;

    logic        pclk;
    logic        rst;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        start_en;
    logic        choice_en;
    logic        first_player;
    logic [8:0]  square_taken;
    logic [8:0]  square_color;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;

    board_state_ctl dut (
        .pclk         (pclk),
        .rst          (rst),
        .xpos         (xpos),
        .ypos         (ypos),
        .mouse_left   (mouse_left),
        .start_en     (start_en),
        .choice_en    (choice_en),
        .first_player (first_player),
        .square_taken (square_taken),
        .square_color (square_color),
        .turn         (turn),
        .winner       (winner),
        .game_over    (game_over)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- game model ----------------
    int m_owner[9];          // -1 empty, 0 blue, 1 yellow
    int m_turn;
    int m_winner;
    int m_over;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int cx[3] = '{170, 512, 854};
    int cy[3] = '{128, 383, 638};
    int col_lo[3] = '{0, 342, 685};
    int col_hi[3] = '{339, 682, 1023};
    int row_lo[3] = '{0, 259, 510};
    int row_hi[3] = '{256, 507, 767};

    function automatic int sq_of(input int x, input int y);
        int c;
        int r;
        c = -1;
        r = -1;
        for (int i = 0; i < 3; i++) begin
            if (x >= col_lo[i] && x <= col_hi[i]) c = i;
            if (y >= row_lo[i] && y <= row_hi[i]) r = i;
        end
        if (c < 0 || r < 0) return -1;
        return r * 3 + c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) m_owner[i] = -1;
        m_turn = 0;
        m_winner = 0;
        m_over = 0;
    endtask

    task automatic model_reset(input int fp);
        model_clear();
        m_turn = fp;
    endtask

    task automatic model_move(input int sq);
        int full;
        if (m_over != 0 || sq < 0 || m_owner[sq] != -1) return;
        m_owner[sq] = m_turn;
        m_turn = 1 - m_turn;
        for (int l = 0; l < 8; l++) begin
            int o;
            o = m_owner[lines[l][0]];
            if (o >= 0 && m_owner[lines[l][1]] == o && m_owner[lines[l][2]] == o) begin
                m_winner = o + 1;
                m_over = 1;
            end
        end
        full = 1;
        for (int i = 0; i < 9; i++) if (m_owner[i] == -1) full = 0;
        if (m_over == 0 && full != 0) begin
            m_winner = 3;
            m_over = 1;
        end
    endtask

    function automatic logic [8:0] exp_taken();
        logic [8:0] v;
        for (int i = 0; i < 9; i++) v[i] = (m_owner[i] != -1);
        return v;
    endfunction

    function automatic logic [8:0] exp_color();
        logic [8:0] v;
        for (int i = 0; i < 9; i++) v[i] = (m_owner[i] == 1);
        return v;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_board(input string tag);
        check_eq({tag, ".taken"}, 32'(square_taken), 32'(exp_taken()));
        check_eq({tag, ".color"}, 32'(square_color & square_taken), 32'(exp_color()));
        check_eq({tag, ".turn"},  32'(turn),      32'(m_turn));
        check_eq({tag, ".winner"}, 32'(winner),   32'(m_winner));
        check_eq({tag, ".over"},  32'(game_over), 32'(m_over));
    endtask

    // Press at (x,y) for `hold` cycles; glitch re-presses while the move is in flight.
    task automatic do_click(input int x, input int y, input int hold, input bit glitch);
        logic [8:0] old_taken;
        int n;
        old_taken = exp_taken();
        xpos = 12'(x);
        ypos = 12'(y);
        mouse_left = 1'b1;
        model_move(sq_of(x, y));
        n = (hold > 4) ? hold : 4;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == 1) begin
                xpos = 12'($urandom_range(0, 4095));
                ypos = 12'($urandom_range(0, 4095));
            end
            if (glitch) begin
                if (i == 1)      mouse_left = 1'b0;
                else if (i == 2) mouse_left = 1'b1;
                else if (i == 3) mouse_left = 1'b0;
            end else if (i == hold) begin
                mouse_left = 1'b0;
            end
            if (i == 2) check_eq("lat.taken_n2", 32'(square_taken), 32'(old_taken));
            if (i == 3) begin
                check_eq("lat.taken_n3", 32'(square_taken), 32'(exp_taken()));
                check_eq("lat.color_n3", 32'(square_color & square_taken), 32'(exp_color()));
                check_eq("lat.turn_n3",  32'(turn), 32'(m_turn));
            end
            if (i == 4) begin
                check_eq("lat.winner_n4", 32'(winner), 32'(m_winner));
                check_eq("lat.over_n4",   32'(game_over), 32'(m_over));
            end
        end
        mouse_left = 1'b0;
        tick();
    endtask

    task automatic click_sq(input int s);
        do_click(cx[(s - 1) % 3], cy[(s - 1) / 3], 2, 1'b0);
    endtask

    task automatic restart(input logic fp);
        start_en = 1'b0;
        tick();
        first_player = fp;
        start_en = 1'b1;
        tick();
        model_reset(int'(fp));
        check_board("restart");
    endtask

    initial begin
        int s;
        int x;
        int y;
        int hold;
        bit gl;

        rst = 1'b1;
        start_en = 1'b0;
        choice_en = 1'b0;
        first_player = 1'b0;
        mouse_left = 1'b0;
        xpos = '0;
        ypos = '0;
        model_clear();
        repeat (3) tick();
        check_board("reset");
        rst = 1'b0;
        tick();
        check_board("idle_hold");

        // First game: one move, gap/out-of-range and occupied-square clicks.
        start_en = 1'b1;
        tick();
        model_reset(0);
        check_board("activate");
        do_click(800, 300, 2, 1'b0);
        check_eq("first_move.taken", 32'(square_taken), 32'h020);
        check_eq("first_move.turn", 32'(turn), 32'd1);
        do_click(341, 100, 2, 1'b0);
        do_click(1100, 100, 2, 1'b0);
        do_click(684, 258, 2, 1'b0);
        do_click(500, 800, 2, 1'b0);
        check_board("gaps");
        do_click(800, 300, 2, 1'b0);
        check_board("occupied");

        // Blue wins the top row; later clicks are ignored.
        restart(1'b0);
        click_sq(1); click_sq(4); click_sq(2); click_sq(5); click_sq(3);
        check_eq("row_win.winner", 32'(winner), 32'd1);
        check_eq("row_win.over", 32'(game_over), 32'd1);
        click_sq(9);
        check_board("after_over");

        // Full board without a line.
        restart(1'b0);
        click_sq(1); click_sq(3); click_sq(2); click_sq(4); click_sq(6);
        click_sq(5); click_sq(7); click_sq(8); click_sq(9);
        check_eq("draw.winner", 32'(winner), 32'd3);

        // Ninth move completes the 1-5-9 diagonal.
        restart(1'b0);
        click_sq(1); click_sq(3); click_sq(2); click_sq(4); click_sq(5);
        click_sq(7); click_sq(6); click_sq(8); click_sq(9);
        check_eq("ninth_win.winner", 32'(winner), 32'd1);
        check_eq("ninth_win.full", 32'(square_taken), 32'h1ff);

        // Long hold counts once.
        restart(1'b1);
        do_click(cx[1], cy[1], 50, 1'b0);
        check_board("held50");
        click_sq(5);
        click_sq(1);
        check_board("after_held");

        // Game deactivated while the click is being decoded.
        xpos = 12'(cx[0]);
        ypos = 12'(cy[2]);
        mouse_left = 1'b1;
        tick();
        choice_en = 1'b1;
        tick();
        mouse_left = 1'b0;
        repeat (3) tick();
        check_board("abort_decode");
        choice_en = 1'b0;
        tick();
        model_reset(int'(first_player));
        check_board("reactivate");

        // Reset in the middle of a move.
        click_sq(2);
        xpos = 12'(cx[2]);
        ypos = 12'(cy[0]);
        mouse_left = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        mouse_left = 1'b0;
        tick();
        model_clear();
        check_board("rst_mid");
        rst = 1'b0;
        tick();
        model_reset(int'(first_player));
        check_board("rst_release");

        // Random games.
        for (int g = 0; g < 8; g++) begin
            restart(1'($urandom_range(0, 1)));
            for (int k = 0; k < 14; k++) begin
                if ($urandom_range(0, 9) < 7) begin
                    s = int'($urandom_range(0, 8));
                    x = int'($urandom_range(col_lo[s % 3], col_hi[s % 3]));
                    y = int'($urandom_range(row_lo[s / 3], row_hi[s / 3]));
                end else begin
                    x = int'($urandom_range(0, 1199));
                    y = int'($urandom_range(0, 899));
                end
                hold = int'($urandom_range(1, 6));
                gl = (sq_of(x, y) >= 0) && ($urandom_range(0, 3) == 0);
                if (gl) hold = 1;
                do_click(x, y, hold, gl);
            end
            check_board("rand_game");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_state_ctl.md
BOARD_STATE_CTL -- requirements
Module: board_state_ctl

Interface
REQ-001 pclk  input  1  pixel clock; sole clock, all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 xpos  input  12  mouse horizontal pixel position, 0..1023 valid.
REQ-004 ypos  input  12  mouse vertical pixel position, 0..767 valid.
REQ-005 mouse_left  input  1  left button level, synchronous to pclk.
REQ-006 start_en  input  1  game screen enabled.
REQ-007 choice_en  input  1  colour-choice screen active; game active only when start_en=1 and choice_en=0.
REQ-008 first_player  input  1  colour of first mover: 0 blue, 1 yellow.
REQ-009 square_taken  output  9  bit i=1: square i+1 occupied; drives per-square draw stages.
REQ-010 square_color  output  9  bit i: owner of square i+1, 0 blue, 1 yellow; meaningful only when taken.
REQ-011 turn  output  1  colour of player to move.
REQ-012 winner  output  2  00 none, 01 blue, 10 yellow, 11 draw.
REQ-013 game_over  output  1  game finished, further clicks ignored.

Function
REQ-014 Squares numbered 1..9 row-major; columns: col0 x 0..339, col1 x 342..682, col2 x 685..1023; rows: row0 y 0..256, row1 y 259..507, row2 y 510..767.
REQ-015 Coordinates in grid-line gaps or outside 1023/767 SHALL map to "no square"; click discarded.
REQ-016 mouse_left registered every cycle into mouse_left_d; click = mouse_left & ~mouse_left_d.
REQ-017 FSM states: IDLE, WAIT_CLICK, DECODE, UPDATE, CHECK, OVER.
REQ-018 IDLE: while game inactive, hold; board, winner, game_over held.
REQ-019 IDLE->WAIT_CLICK when active; same edge clears square_taken, square_color, winner, game_over, loads turn=first_player.
REQ-020 WAIT_CLICK: on click, capture xpos/ypos into registers, go DECODE; else stay.
REQ-021 DECODE: register square index from captured coords; no square -> WAIT_CLICK, else UPDATE.
REQ-022 UPDATE: square free -> set taken bit, color bit=turn, toggle turn, go CHECK; square taken -> WAIT_CLICK, no change.
REQ-023 CHECK: evaluate 3 rows, 3 columns, 2 diagonals same colour all taken; line found -> winner=01/10 per colour, game_over=1, go OVER; else all 9 taken -> winner=11, game_over=1, OVER; else WAIT_CLICK.
REQ-024 Win takes priority over draw when ninth move completes a line.
REQ-025 Latency: click detected at cycle N -> square_taken bit visible N+3, winner/game_over visible N+4.
REQ-026 Clicks arriving in DECODE, UPDATE, CHECK SHALL be dropped, not queued.
REQ-027 OVER: ignore clicks; outputs held until game inactive.
REQ-028 Game going inactive in any non-IDLE state -> IDLE next edge, in-flight move aborted (no board write if not yet in UPDATE).
REQ-029 Held button produces exactly one click; re-press requires a released cycle.
REQ-030 All outputs registered.

Reset
REQ-031 rst=1: state IDLE, mouse_left_d=0, square_taken=0, square_color=0, turn=0, winner=00, game_over=0, captured coords 0.
REQ-032 rst overrides all other inputs same edge; reset mid-move discards move.

Verification
REQ-033 Activate with first_player=0; click (800,300) -> square_taken=9'b000100000, square_color bit5=0, turn=1 at N+3.
REQ-034 Click (341,100) gap and (1100,100) out-of-range -> no board change, FSM back in WAIT_CLICK after 2 cycles.
REQ-035 Second click on occupied square 6 -> board and turn unchanged.
REQ-036 Blue takes 1,2,3 alternating with yellow 4,5 -> winner=01, game_over=1 at N+4 of third blue click; later clicks ignored.
REQ-037 Fill board without line (blue 1,3,4,8,9? no -- blue 1,2,6,7,9 / yellow 3,4,5,8 ordered legally) -> winner=11; ninth-move line case -> winner colour, not 11.
REQ-038 Button held 50 cycles -> one move; choice_en raised mid-DECODE -> IDLE, no write; rst mid-game -> all outputs zero next cycle.
